// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the serial adder/subtractor.
// The master side is the sequencer. The slave side is the arithmetic unit.
interface serial_addsub_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] dA;
    logic [WIDTH-1:0] dB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carryOut;
    logic             overflow;

    modport master (
        output start, sub, cin, dA, dB,
        input  busy, done, result, carryOut, overflow
    );

    modport slave (
        input  start, sub, cin, dA, dB,
        output busy, done, result, carryOut, overflow
    );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle serial adder/subtractor that consumes DIGIT bits per clock, LSB digit first.
// Subtraction is performed as A + ~B + ~borrow, so carryOut reads as NOT borrow.
module serial_addsub #(
    parameter int WIDTH = 64,
    parameter int DIGIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    serial_addsub_if.slave bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : gBadParams
        $fatal(1, "serial_addsub: DIGIT must be >= 1 and divide WIDTH");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           stateNext;
    logic [WIDTH-1:0] regA;
    logic [WIDTH-1:0] regB;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             carryOut;
    logic             overflow;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   digitSum;
    logic             carryIntoMsb;
    logic             lastDigit;

    // The carry into the digit's top bit is recovered from the sum bit and both operand bits.
    assign digitSum     = {1'b0, regA[DIGIT-1:0]} + {1'b0, regB[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    assign carryIntoMsb = digitSum[DIGIT-1] ^ regA[DIGIT-1] ^ regB[DIGIT-1];
    assign lastDigit    = (cnt == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.start) stateNext = RUN;
            RUN:     if (lastDigit) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (state != IDLE);
        bus.done     = (state == DONE);
        bus.result   = result;
        bus.carryOut = carryOut;
        bus.overflow = overflow;
    end

    // Each new digit enters the result at the top, so after N digits the result is aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regA     <= '0;
            regB     <= '0;
            result   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            carryOut <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        regA   <= bus.dA;
                        regB   <= bus.sub ? ~bus.dB : bus.dB;
                        carry  <= bus.cin ^ bus.sub;
                        cnt    <= '0;
                        result <= '0;
                    end
                end
                RUN: begin
                    regA   <= regA >> DIGIT;
                    regB   <= regB >> DIGIT;
                    result <= (result >> DIGIT) | (WIDTH'(digitSum[DIGIT-1:0]) << (WIDTH - DIGIT));
                    carry  <= digitSum[DIGIT];
                    cnt    <= cnt + CW'(1);
                    if (lastDigit) begin
                        carryOut <= digitSum[DIGIT];
                        overflow <= carryIntoMsb ^ digitSum[DIGIT];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised multi-cycle serial adder/subtractor processing `DIGIT` bits per clock over `WIDTH`-bit operands, with carry/borrow-in, signed-overflow flag and a start/busy/done handshake. It generalises the fixed 64-bit, 4-bit-per-cycle serial adder in width, digit size and mode (add/subtract). It is the arithmetic unit that sequencers drive when a full-width parallel adder is too costly.

## Interface

Parameters:
- `WIDTH`, 64, operand/result width in bits. Must be ≥ 1.
- `DIGIT`, 4, bits processed per cycle. Must be ≥ 1 and divide `WIDTH`; elaboration fails otherwise.
- Derived: `N = WIDTH/DIGIT`, the number of digit cycles. The counter width is `$clog2(N+1)`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `sub`  in  1  0 = add, 1 = subtract (A − B); sampled with `start`.
- `cin`  in  1  carry-in (add) / borrow-in (subtract); sampled with `start`.
- `dA`  in  WIDTH  operand A; sampled with `start`.
- `dB`  in  WIDTH  operand B; sampled with `start`.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse; `result`/flags valid.
- `result`  out  WIDTH  sum/difference. Held from `done` until the next accepted `start`.
- `carryOut`  out  1  add: carry out of the MSB. Subtract: NOT borrow (1 = no borrow).
- `overflow`  out  1  two's-complement signed overflow of the operation.

## Operation

- States: IDLE, RUN, DONE.
- **IDLE**, with `start`=1 → RUN. On that edge:
  - Load A into `regA`.
  - Load B into `regB`; if `sub`=1, load ~B.
  - Set `carry` to `cin ^ sub`. Subtract computes A + ~B + ~borrow.
  - Clear the digit counter and `result`.
- **RUN**, each edge:
  - `{c, s} = regA[DIGIT-1:0] + regB[DIGIT-1:0] + carry` (DIGIT+1 bits).
  - Shift `regA` and `regB` right by DIGIT.
  - Shift `result` right by DIGIT, inserting `s` at `result[WIDTH-1 -: DIGIT]`.
  - `carry` ← `c`; counter increments.
  - When counter reaches N−1 (last digit), that same edge also does the following and moves to DONE:
    - `carryOut` ← `c`.
    - `overflow` ← carry into bit DIGIT−1 of the digit XOR `c`.
- **DONE**: `done`=1 for exactly one cycle → IDLE.
- `start` is ignored in RUN and DONE. No queuing.
- `sub`, `cin`, `dA`, `dB` may change freely after acceptance.
- `result`, `carryOut` and `overflow` are registered. They are only meaningful when `done`=1 and thereafter until the next accepted `start`. During RUN, `result` shows partial shifted contents.
- Arithmetic is modulo 2^WIDTH. No saturation.

## Timing

- **Reset** (async, any state): state ← IDLE. `busy`, `done`, `result`, `carryOut`, `overflow`, counter, `carry`, `regA` and `regB` all ← 0.
  - Reset mid-RUN aborts the operation; no `done` is emitted.
  - After `rst` deasserts, the first `start` is accepted at the next rising edge.
- **Latency**:
  - `start` sampled at edge k; `busy`=1 from edge k.
  - Digits are processed at edges k+1 … k+N.
  - `done`=1 in the cycle after edge k+N.
  - `busy`=0 and IDLE after edge k+N+1.
- **Throughput**: minimum `start` spacing is N+2 cycles.
  - A `start` held high continuously is accepted again at edge k+N+2.
- **N = 1** (`DIGIT` = `WIDTH`): RUN lasts one edge; `done` appears 2 cycles after `start`.
- `start` asserted in the same cycle `done` is high is ignored. The state is DONE, not IDLE.

## Test plan

- **Add, WIDTH=64, DIGIT=4**, `dA`=0xFFFF_FFFF_FFFF_FFFF, `dB`=1, `cin`=0, `sub`=0:
  - `done` exactly 17 cycles after `start` edge.
  - `result`=0, `carryOut`=1, `overflow`=0.
- **Signed overflow add, WIDTH=64, DIGIT=4**, `dA`=0x7FFF_FFFF_FFFF_FFFF, `dB`=1:
  - `result`=0x8000_0000_0000_0000, `carryOut`=0, `overflow`=1.
- **Subtract, WIDTH=64, DIGIT=4**, `sub`=1, `cin`=0:
  - `dA`=5, `dB`=7 → `result`=0xFFFF_FFFF_FFFF_FFFE, `carryOut`=0 (borrow).
  - `dA`=7, `dB`=5, `cin`=1 (borrow-in) → `result`=1, `carryOut`=1.
- **Handshake**, with `start` held high and operands changed mid-RUN:
  - `result` reflects the operands sampled at acceptance.
  - A second `start` is accepted only at edge k+18.
  - `done` is exactly one cycle wide.
- **Reset mid-operation**: assert `rst` asynchronously (between edges) at RUN digit 8.
  - Outputs are 0 immediately; no `done` is emitted.
  - A subsequent `start` with 3+4 gives `result`=7.
- **Parameter corners**:
  - WIDTH=8, DIGIT=8: `dA`=0x80, `dB`=0x80 → `result`=0, `carryOut`=1, `overflow`=1, `done` 2 cycles after `start`.
  - WIDTH=8, DIGIT=1: same operands give the same result after 9 cycles.
